// File: rtl/barrido_sistema.sv
// Truth-table sweeper: drives {A,B,C,D} through all 16 vectors and captures h_in per vector.
// Optional golden comparison on the error output is enabled by defining SISTEMA_CHECK_EN.
module barrido_sistema #(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] GOLDEN = 16'h0FCD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        h_in,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] tabla,
    output logic        error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = SETTLE[3:0];

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tabla_q, tabla_d;
    logic [3:0]  abcd_q, abcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        last_sample;

    assign accept      = (state_q == ST_IDLE) && start && !abort;
    assign last_sample = (state_q == ST_SAMPLE) && !abort && (idx_q == 4'd15);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tabla_d = tabla_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tabla_d = '0;
                    idx_d   = '0;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tabla_d[idx_q] = h_in;
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = SETTLE_LD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        abcd_d = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tabla_q <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tabla_q <= tabla_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {A, B, C, D} = abcd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tabla        = tabla_q;

`ifdef SISTEMA_CHECK_EN
    logic error_q, error_d;

    // Compared against the completed table so the flag is valid in the DONE cycle.
    always_comb begin
        error_d = error_q;
        if (accept)           error_d = 1'b0;
        else if (last_sample) error_d = (tabla_d != GOLDEN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) error_q <= 1'b0;
        else        error_q <= error_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_barrido_sistema.sv
// Randomized self-checking bench for barrido_sistema (SETTLE=1 and SETTLE=3 instances).
module tb_barrido_sistema;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] mask0 = '0;
    logic [15:0] mask1 = '0;

    logic        a0, b0, c0, d0, busy0, done0, err0, h0;
    logic        a1, b1, c1, d1, busy1, done1, err1, h1;
    logic [15:0] tab0, tab1;

    int errors = 0;
    int checks = 0;

    localparam int S0 = 1;
    localparam int S1 = 3;

    function automatic logic sys_h(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return a ? ~b : (c | (~b & ~d));
    endfunction

    function automatic logic [15:0] exp_tab(input logic [15:0] m);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = sys_h(4'(i)) ^ m[i];
        return t;
    endfunction

    function automatic logic [22:0] obs(input int sel);
        if (sel == 1) return {busy1, done1, a1, b1, c1, d1, tab1, err1};
        return {busy0, done0, a0, b0, c0, d0, tab0, err0};
    endfunction

    assign h0 = sys_h({a0, b0, c0, d0}) ^ mask0[{a0, b0, c0, d0}];
    assign h1 = sys_h({a1, b1, c1, d1}) ^ mask1[{a1, b1, c1, d1}];

    always #5 clk = ~clk;

    barrido_sistema #(.SETTLE(S0), .GOLDEN(16'h0FCD)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .h_in(h0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .tabla(tab0), .error(err0)
    );

    barrido_sistema #(.SETTLE(S1), .GOLDEN(16'h0FCD)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .h_in(h1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
        .tabla(tab1), .error(err1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep: every busy cycle, the done cycle and one hold cycle are checked.
    task automatic sweep(input int sel, input int restart_at);
        int          s;
        int          len;
        int          n;
        logic [15:0] et;
        logic        ee;
        logic [22:0] o, e;
        s   = (sel == 1) ? S1 : S0;
        len = 16 * (s + 1);
        et  = exp_tab((sel == 1) ? mask1 : mask0);
`ifdef SISTEMA_CHECK_EN
        ee = (et != 16'h0FCD);
`else
        ee = 1'b0;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < len; c++) begin
            n = c / (s + 1);
            e = {1'b1, 1'b0, 4'(n), et & 16'((32'd1 << n) - 32'd1), 1'b0};
            o = obs(sel);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sweep_cycle dut%0d c=%0d got=%h exp=%h", sel, c, o, e);
            end
            start = (c == restart_at);
            step();
        end
        start = 1'b0;
        e = {1'b0, 1'b1, 4'd0, et, ee};
        o = obs(sel);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sweep_done dut%0d got=%h exp=%h", sel, o, e);
        end
        step();
        e = {1'b0, 1'b0, 4'd0, et, ee};
        o = obs(sel);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sweep_hold dut%0d got=%h exp=%h", sel, o, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'($urandom);
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(0) !== 23'd0 || obs(1) !== 23'd0) begin
                errors++;
                $display("FAIL reset_state k=%0d got0=%h got1=%h exp=0", k, obs(0), obs(1));
            end
            rst_n = 1'b1;
            start = 1'b0;
            abort = 1'b0;
            step();
        end
    endtask

    task automatic test_golden();
        mask0 = '0;
        sweep(0, -1);
        checks++;
        if (tab0 !== 16'h0FCD) begin
            errors++;
            $display("FAIL golden_table got=%h exp=0fcd", tab0);
        end
    endtask

    task automatic test_random_sweeps();
        for (int t = 0; t < 4; t++) begin
            mask0 = 16'($urandom);
            repeat ($urandom_range(0, 3)) step();
            sweep(0, int'($urandom_range(0, 30)));
        end
    endtask

    task automatic test_check_error();
        logic exp_err;
        mask0 = ~exp_tab(16'h0000);
        sweep(0, -1);
`ifdef SISTEMA_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (4) step();
        checks++;
        if (tab0 !== 16'hFFFF || err0 !== exp_err) begin
            errors++;
            $display("FAIL error_hold got tabla=%h err=%b exp tabla=ffff err=%b", tab0, err0, exp_err);
        end
        mask0 = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (tab0 !== 16'h0000 || err0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL error_clear got tabla=%h err=%b busy=%b exp 0000/0/1", tab0, err0, busy0);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_settle3();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mask1 = '0;
        sweep(1, -1);
        checks++;
        if (tab1 !== 16'h0FCD) begin
            errors++;
            $display("FAIL settle3_table got=%h exp=0fcd", tab1);
        end
        mask1 = 16'($urandom);
        sweep(1, int'($urandom_range(0, 60)));
    endtask

    task automatic test_abort();
        int          v;
        int          k;
        logic [15:0] et;
        logic [22:0] e;
        logic [4:0]  low;
        for (int t = 0; t < 3; t++) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            v = (t == 0) ? 5 : int'($urandom_range(0, 15));
            mask0 = (t == 0) ? 16'h0000 : 16'($urandom);
            et = exp_tab(mask0);
            k = v * (S0 + 1) + int'($urandom_range(0, S0));
            start = 1'b1;
            step();
            start = 1'b0;
            for (int c = 0; c < k; c++) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            e = {1'b0, 1'b0, 4'd0, et & 16'((32'd1 << v) - 32'd1), 1'b0};
            checks++;
            if (obs(0) !== e) begin
                errors++;
                $display("FAIL abort_state v=%0d got=%h exp=%h", v, obs(0), e);
            end
            step();
            checks++;
            if (obs(0) !== e) begin
                errors++;
                $display("FAIL abort_no_done v=%0d got=%h exp=%h", v, obs(0), e);
            end
            if (t == 0) begin
                low = tab0[4:0];
                checks++;
                if (low !== 5'b01101) begin
                    errors++;
                    $display("FAIL abort_v5_bits got=%b exp=01101", low);
                end
            end
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int k2 = 0; k2 < 2; k2++) begin
            checks++;
            if (busy0 !== 1'b0 || {a0, b0, c0, d0} !== 4'd0) begin
                errors++;
                $display("FAIL abort_wins k=%0d got busy=%b abcd=%b exp 0", k2, busy0, {a0, b0, c0, d0});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mask0 = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 18; c++) begin
            checks++;
            if (busy0 !== 1'b1 || {a0, b0, c0, d0} !== 4'(c / 2)) begin
                errors++;
                $display("FAIL restart_ignored c=%0d got busy=%b abcd=%0d exp 1/%0d", c, busy0, {a0, b0, c0, d0}, c / 2);
            end
            start = (c == 3);
            step();
        end
        start = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (obs(0) !== 23'd0) begin
            errors++;
            $display("FAIL midsweep_reset got=%h exp=0", obs(0));
        end
        step();
        checks++;
        if (obs(0) !== 23'd0) begin
            errors++;
            $display("FAIL reset_no_done got=%h exp=0", obs(0));
        end
        mask0 = 16'($urandom);
        sweep(0, -1);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_random_sweeps();
        test_check_error();
        test_settle3();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrido_sistema.md
BARRIDO_SISTEMA -- requirements
Module: barrido_sistema

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1: number of settle cycles per vector before sampling; legal range 1..15.
REQ-002 The block SHALL have parameter GOLDEN, default 16'h0FCD: expected truth table of H = A ? ~B : (C | (~B & ~D)); bit i corresponds to {A,B,C,D} = i.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a 16-vector sweep.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel a sweep in progress.
REQ-007 The block SHALL have port h_in, input, 1 bit: H output of the combinational system under control.
REQ-008 The block SHALL have ports A, B, C, D, each output, 1 bit: registered stimulus to the system under control.
REQ-009 The block SHALL have port busy, output, 1 bit: sweep in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 The block SHALL have port tabla, output, 16 bits: captured truth table; bit i = h_in sampled for vector i.
REQ-012 The block SHALL have port error, output, 1 bit: mismatch flag (see Configuration).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE, start=1 SHALL clear tabla, set the vector index idx to 0, load the settle counter with SETTLE, and move to SETTLE.
REQ-015 {A,B,C,D} SHALL equal idx[3:0] (A = MSB) in SETTLE and SAMPLE, and SHALL be 4'b0000 in IDLE and DONE.
REQ-016 SETTLE SHALL last exactly SETTLE cycles, then move to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle and write tabla[idx] = h_in.
REQ-018 After SAMPLE, if idx < 15, the block SHALL increment idx, reload the settle counter and return to SETTLE; if idx = 15, it SHALL move to DONE.
REQ-019 DONE SHALL last 1 cycle with done=1 and then return to IDLE.
REQ-020 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-021 If start is sampled on edge t, busy SHALL be high for 16*(SETTLE+1) cycles, and done SHALL be high in the cycle immediately following the last busy cycle.
REQ-022 start SHALL be ignored while busy=1 or in DONE; it is not queued.
REQ-023 abort=1 in SETTLE or SAMPLE SHALL return the FSM to IDLE on the next edge: no done pulse, no tabla write in that cycle, earlier bits retained, error unchanged.
REQ-024 If abort and start are both high in IDLE, abort SHALL win and no sweep SHALL start.
REQ-025 tabla SHALL hold its value in IDLE until the next accepted start.
REQ-026 idx SHALL be 4 bits wide and SHALL never wrap past 15 within a sweep.

Reset
REQ-027 With rst_n=0 at a rising edge, the FSM SHALL go to IDLE with idx=0, settle counter=0, A=B=C=D=0, busy=0, done=0, tabla=16'h0000, error=0.
REQ-028 Reset SHALL take priority over start and abort, including mid-sweep, and SHALL cause no done pulse.

Configuration
REQ-029 With macro SISTEMA_CHECK_EN defined, error SHALL be set in the DONE cycle to (tabla != GOLDEN), hold until the next accepted start, and be cleared on that start.
REQ-030 Without SISTEMA_CHECK_EN, error SHALL be constant 0 and no comparison logic SHALL be present; the port list SHALL be unchanged.

Verification
REQ-031 Reset, then a single-cycle start with SETTLE=1 and a correct system model -> busy high 32 cycles, done pulse in cycle 33, tabla=16'h0FCD, error=0.
REQ-032 With SISTEMA_CHECK_EN defined and the model forced to h_in=1 for every vector -> tabla=16'hFFFF and error=1 in the DONE cycle; error stays 1 in IDLE.
REQ-033 With SETTLE=3 -> each vector holds {A,B,C,D} for 4 cycles, busy lasts 64 cycles, and tabla=16'h0FCD.
REQ-034 abort asserted during vector 5 (SETTLE=1) -> IDLE next cycle, no done pulse, tabla[4:0]=5'b01101, tabla[15:5]=0.
REQ-035 start pulsed again while busy, and rst_n=0 at vector 9 -> the second start has no effect; after reset all outputs are 0 and a later start runs a full sweep correctly.
